// File: rtl/alu_div_seq.sv
// alu_div_seq: iterative radix-2 restoring divider, signed/unsigned, one quotient bit per clock
module alu_div_seq #(
  parameter int OPR_L = 32,
  parameter int CNT_L = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sgn_i,
  input  logic [OPR_L-1:0] a_i,
  input  logic [OPR_L-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [OPR_L-1:0] q_o,
  output logic [OPR_L-1:0] r_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;
  logic [OPR_L-1:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d, a_q, a_d, q_q, q_d, r_q, r_d;
  logic qs_q, qs_d, rs_q, rs_d, z_q, z_d, done_q, done_d, div0_q, div0_d;
  logic [CNT_L-1:0] cnt_q, cnt_d;
  logic [OPR_L:0] rem_sh, trial;
  logic last;
  assign last = cnt_q == CNT_L'(OPR_L - 1);
  assign rem_sh = {rem_q, dvd_q[OPR_L-1]};
  assign trial = rem_sh - {1'b0, dsr_q};
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign div0_o = div0_q;
  assign q_o = q_q;
  assign r_o = r_q;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state: IDLE -> CALC on start, CALC -> FIX after the last iteration, FIX -> IDLE
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && start_i) state_d = CALC;
    else if (state_q == CALC && last) state_d = FIX;
    else if (state_q == FIX) state_d = IDLE;
  end
  // datapath: operand capture, one restoring step per CALC cycle, sign fix-up at FIX
  always_comb begin
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    a_d    = a_q;
    q_d    = q_q;
    r_d    = r_q;
    qs_d   = qs_q;
    rs_d   = rs_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    div0_d = div0_q;
    done_d = 1'b0;
    if (state_q == IDLE && start_i) begin
      dvd_d = (sgn_i && a_i[OPR_L-1]) ? -a_i : a_i;
      dsr_d = (sgn_i && b_i[OPR_L-1]) ? -b_i : b_i;
      qs_d  = (a_i[OPR_L-1] ^ b_i[OPR_L-1]) & sgn_i;
      rs_d  = a_i[OPR_L-1] & sgn_i;
      z_d   = b_i == '0;
      a_d   = a_i;
      rem_d = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      rem_d = trial[OPR_L] ? rem_sh[OPR_L-1:0] : trial[OPR_L-1:0];
      dvd_d = {dvd_q[OPR_L-2:0], ~trial[OPR_L]};
      cnt_d = cnt_q + CNT_L'(1);
    end else if (state_q == FIX) begin
      q_d    = z_q ? '1 : (qs_q ? -dvd_q : dvd_q);
      r_d    = z_q ? a_q : (rs_q ? -rem_q : rem_q);
      div0_d = z_q;
      done_d = 1'b1;
    end
  end
  // datapath registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      a_q    <= '0;
      q_q    <= '0;
      r_q    <= '0;
      qs_q   <= 1'b0;
      rs_q   <= 1'b0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      div0_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      a_q    <= a_d;
      q_q    <= q_d;
      r_q    <= r_d;
      qs_q   <= qs_d;
      rs_q   <= rs_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      div0_q <= div0_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: directed and random checks of alu_div_seq against an arithmetic model
module tb_alu_div_seq;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, sgn_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic busy_o, done_o, div0_o;
  logic [31:0] q_o, r_o;
  int checks = 0, errors = 0;

  alu_div_seq #(.OPR_L(32), .CNT_L(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sgn_i(sgn_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .div0_o(div0_o), .q_o(q_o), .r_o(r_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint la, lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    z = b == 0;
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      q = 32'(la / lb);
      r = 32'(la % lb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    int n, nb;
    logic [31:0] eq, er;
    logic ez;
    model(a, b, s, eq, er, ez);
    @(negedge clk);
    a_i = a; b_i = b; sgn_i = s; start_i = 1'b1;
    n = 0; nb = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        start_i = 1'b0; a_i = $urandom; b_i = $urandom; sgn_i = 1'($urandom);
      end
      if (busy_o) nb++;
    end while (!done_o && n < 100);
    check({tag, "_lat"}, 64'(n), 64'd34);
    check({tag, "_busy"}, 64'(nb), 64'd33);
    check({tag, "_q"}, 64'(q_o), 64'(eq));
    check({tag, "_r"}, 64'(r_o), 64'(er));
    check({tag, "_div0"}, 64'(div0_o), 64'(ez));
  endtask

  initial begin
    int n, nd;
    logic [31:0] ra, rb;
    logic rs;
    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_div0", 64'(div0_o), 64'd0);
    check("rst_q", 64'(q_o), 64'd0);
    check("rst_r", 64'(r_o), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, "u100_7");
    check("u100_7_q_const", 64'(q_o), 64'd14);
    check("u100_7_r_const", 64'(r_o), 64'd2);
    run_op(-32'sd7, 32'd2, 1'b1, "s-7_2");
    check("s-7_2_q_const", 64'(q_o), 64'hFFFF_FFFD);
    check("s-7_2_r_const", 64'(r_o), 64'hFFFF_FFFF);
    run_op(32'd7, -32'sd2, 1'b1, "s7_-2");
    check("s7_-2_r_const", 64'(r_o), 64'd1);
    run_op(32'd5, 32'd0, 1'b0, "u5_0");
    check("u5_0_r_const", 64'(r_o), 64'd5);
    run_op(32'd5, 32'd0, 1'b1, "s5_0");
    check("s5_0_div0_const", 64'(div0_o), 64'd1);
    run_op(32'd20, 32'd3, 1'b1, "clr_div0");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "smin_m1");
    check("smin_m1_q_const", 64'(q_o), 64'h8000_0000);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "umax_1");

    // start while busy must be ignored
    @(negedge clk);
    a_i = 32'd1; b_i = 32'd1; sgn_i = 1'b0; start_i = 1'b1;
    n = 0; nd = 0;
    repeat (50) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) start_i = 1'b0;
      if (n == 10) begin start_i = 1'b1; a_i = 32'd9; b_i = 32'd3; end
      if (n == 11) start_i = 1'b0;
      if (done_o) begin
        nd++;
        if (nd == 1) begin
          check("ign_lat", 64'(n), 64'd34);
          check("ign_q", 64'(q_o), 64'd1);
          check("ign_r", 64'(r_o), 64'd0);
        end
      end
    end
    check("ign_done_count", 64'(nd), 64'd1);
    run_op(32'd9, 32'd3, 1'b0, "u9_3");
    run_op(32'd9, 32'd3, 1'b0, "b2b_9_3");

    // reset in the middle of an operation
    @(negedge clk);
    a_i = 32'd1000; b_i = 32'd7; sgn_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    check("mid_rst_q", 64'(q_o), 64'd0);
    check("mid_rst_r", 64'(r_o), 64'd0);
    nd = 0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done_o) nd++;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1 if (done_o) nd++;
    end
    check("mid_rst_no_done", 64'(nd), 64'd0);
    run_op(32'd50, 32'd6, 1'b0, "u50_6");
    check("u50_6_q_const", 64'(q_o), 64'd8);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      rs = 1'($urandom);
      run_op(ra, rb, rs, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
